// File: rtl/sram_access_controller_if.sv
// Request/response handshake and SRAM control strobes of the SRAM access controller.
// The bidirectional data bus stays a plain inout port on the controller.
interface sram_access_controller_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic                  ram_chip_select;
   logic                  ram_write_enable;
   logic                  ram_output_enable;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
      input  ram_address, ram_chip_select, ram_write_enable, ram_output_enable
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata,
      output ram_address, ram_chip_select, ram_write_enable, ram_output_enable
   );
endinterface

// File: rtl/sram_access_controller.sv
// Sequencer for a single-port synchronous SRAM on a shared tri-state data bus:
// one command in, one SRAM cycle (or an address error), one response out.
module sram_access_controller #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   sram_access_controller_if.slave        bus_if,
   inout  wire  [DATA_WIDTH-1:0]          ram_data_bus
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRdAddr,
      StRdData,
      StResp
   } t_state;

   localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];

   t_state                r_state;
   t_state                w_state_d;
   logic                  r_req_ready;
   logic                  r_cs;
   logic                  r_we;
   logic                  r_oe;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_rsp_write;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  w_accept;
   logic                  w_in_range;

   assign w_accept   = bus_if.req_valid && r_req_ready;
   assign w_in_range = ({1'b0, bus_if.req_addr} < LP_DEPTH);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               if (!w_in_range) begin
                  w_state_d = StResp;
               end else if (bus_if.req_write) begin
                  w_state_d = StWrite;
               end else begin
                  w_state_d = StRdAddr;
               end
            end
         end
         StWrite:  w_state_d = StResp;
         StRdAddr: w_state_d = StRdData;
         StRdData: w_state_d = StResp;
         StResp: begin
            if (bus_if.rsp_ready) begin
               w_state_d = StIdle;
            end
         end
         default:  w_state_d = StIdle;
      endcase
   end

   // Strobes are decoded from the next state so they are clean flop outputs in each state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_req_ready <= 1'b0;
         r_cs        <= 1'b0;
         r_we        <= 1'b0;
         r_oe        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_write <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_d;
         r_req_ready <= (w_state_d == StIdle);
         r_cs        <= (w_state_d inside {StWrite, StRdAddr, StRdData});
         r_we        <= (w_state_d == StWrite);
         r_oe        <= (w_state_d == StRdData);
         if (w_accept) begin
            r_rsp_write <= bus_if.req_write;
            r_rsp_err   <= !w_in_range;
            r_rsp_rdata <= '0;
            if (w_in_range) begin
               r_addr  <= bus_if.req_addr;
               r_wdata <= bus_if.req_wdata;
            end
         end
         if (r_state == StRdData) begin
            r_rsp_rdata <= ram_data_bus;
         end
      end
   end

   // Write enable doubles as the bus-drive enable: the SRAM never drives while we=1.
   assign ram_data_bus = r_we ? r_wdata : {DATA_WIDTH{1'bz}};

   assign bus_if.req_ready         = r_req_ready;
   assign bus_if.rsp_valid         = (r_state == StResp);
   assign bus_if.rsp_write         = r_rsp_write;
   assign bus_if.rsp_err           = r_rsp_err;
   assign bus_if.rsp_rdata         = r_rsp_rdata;
   assign bus_if.ram_address       = r_addr;
   assign bus_if.ram_chip_select   = r_cs;
   assign bus_if.ram_write_enable  = r_we;
   assign bus_if.ram_output_enable = r_oe;

endmodule

// File: tb/tb_sram_access_controller.sv
// Scoreboard bench: stimulus pushes expected responses from an array memory model,
// a monitor pops and compares them; a behavioural SRAM sits on the tri-state bus.
module tb_sram_access_controller;
   localparam int unsigned AW     = 4;
   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 12;
   localparam int unsigned NWORDS = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();
   wire [DW-1:0] ram_data_bus;

   sram_access_controller #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_if      (bus_if),
      .ram_data_bus(ram_data_bus)
   );

   // Behavioural synchronous SRAM: output buffer latched on a read-cycle edge, driven under oe.
   logic [DW-1:0] sram_mem [NWORDS] = '{default: '0};
   logic [DW-1:0] sram_q = '0;
   wire sram_drive = bus_if.ram_chip_select && bus_if.ram_output_enable &&
                     !bus_if.ram_write_enable;
   assign ram_data_bus = sram_drive ? sram_q : {DW{1'bz}};

   always @(posedge clk) begin
      if (bus_if.ram_chip_select) begin
         if (bus_if.ram_write_enable) sram_mem[bus_if.ram_address] <= ram_data_bus;
         else                         sram_q <= sram_mem[bus_if.ram_address];
      end
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      bit            wr;
      bit            err;
      logic [DW-1:0] rdata;
      int unsigned   lat;
      int unsigned   acc;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] ref_mem [NWORDS];
   bit            bp_arm = 1'b0;

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t        e;
      int unsigned waited = 0;
      bus_if.req_valid = 1'b1;
      forever begin
         if (bus_if.req_ready) begin
            bus_if.req_write = wr;
            bus_if.req_addr  = addr;
            bus_if.req_wdata = data;
            break;
         end
         bus_if.req_write = 1'($urandom);
         bus_if.req_addr  = AW'($urandom);
         bus_if.req_wdata = $urandom;
         waited++;
         if (waited > 100) begin
            chk("req_accept_timeout", 64'(waited), 64'(0));
            bus_if.req_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      e.wr  = wr;
      e.err = (int'(addr) >= int'(DEPTH));
      e.lat = e.err ? 1 : (wr ? 2 : 3);
      e.acc = cyc;
      if (!e.err && wr) ref_mem[addr] = data;
      e.rdata = (!e.err && !wr) ? ref_mem[addr] : '0;
      exp_q.push_back(e);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      bus_if.req_addr  = AW'($urandom);
      bus_if.req_wdata = $urandom;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   // Monitor: compares every presented response, drives rsp_ready, checks bus ownership.
   initial begin
      bit seen      = 1'b0;
      bit hs_last   = 1'b0;
      bit force_rdy = 1'b0;
      int bp_cnt    = 0;
      bus_if.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen    = 1'b0;
            hs_last = 1'b0;
            bp_cnt  = 0;
         end else begin
            if (hs_last) chk("rsp_valid_drop", 64'(bus_if.rsp_valid), 64'(0));
            hs_last = 1'b0;
            if (bus_if.ram_chip_select)
               chk("bus_owner", 64'(bus_if.ram_write_enable && bus_if.ram_output_enable), 64'(0));
            if (bus_if.rsp_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 64'(bus_if.rsp_valid), 64'(0));
                  bus_if.rsp_ready = 1'b1;
               end else begin
                  if (!seen) begin
                     seen = 1'b1;
                     chk("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                     if (bp_arm) begin
                        bp_arm = 1'b0;
                        bp_cnt = 5;
                     end
                  end
                  chk("rsp_write", 64'(bus_if.rsp_write), 64'(exp_q[0].wr));
                  chk("rsp_err", 64'(bus_if.rsp_err), 64'(exp_q[0].err));
                  chk("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(exp_q[0].rdata));
                  if (bp_cnt > 0) begin
                     chk("bp_req_ready", 64'(bus_if.req_ready), 64'(0));
                     chk("bp_cs", 64'(bus_if.ram_chip_select), 64'(0));
                     bp_cnt--;
                     bus_if.rsp_ready = 1'b0;
                     force_rdy = (bp_cnt == 0);
                  end else begin
                     bus_if.rsp_ready = force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0);
                     force_rdy = 1'b0;
                  end
                  if (bus_if.rsp_ready) begin
                     void'(exp_q.pop_front());
                     seen    = 1'b0;
                     hs_last = 1'b1;
                  end
               end
            end else begin
               bus_if.rsp_ready = 1'($urandom);
            end
         end
      end
   end

   initial begin
      int unsigned n;
      for (int i = 0; i < int'(NWORDS); i++) ref_mem[i] = '0;
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = AW'(2);
      bus_if.req_wdata = 32'h1234_5678;

      // Reset held with a pending command
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus_if.req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
      chk("rst_cs", 64'(bus_if.ram_chip_select), 64'(0));
      chk("rst_we", 64'(bus_if.ram_write_enable), 64'(0));
      chk("rst_oe", 64'(bus_if.ram_output_enable), 64'(0));
      chk("rst_rsp_fields",
          64'({bus_if.rsp_write, bus_if.rsp_err, bus_if.rsp_rdata}), 64'(0));
      chk("rst_address", 64'(bus_if.ram_address), 64'(0));
      rst_n = 1'b1;
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(bus_if.req_ready), 64'(1));

      send(1'b1, AW'(5), 32'hDEAD_BEEF);
      send(1'b0, AW'(5), '0);
      drain();

      // Fill every address (12..15 are out of range) then read all back
      for (int i = 0; i < int'(NWORDS); i++) send(1'b1, AW'(i), DW'(32'h1000 + i));
      for (int i = 0; i < int'(NWORDS); i++) send(1'b0, AW'(i), '0);
      drain();

      // Out-of-range read: no SRAM cycle
      send(1'b0, AW'(13), '0);
      chk("oor_cs_0", 64'(bus_if.ram_chip_select), 64'(0));
      @(negedge clk);
      chk("oor_cs_1", 64'(bus_if.ram_chip_select), 64'(0));
      drain();

      bp_arm = 1'b1;
      send(1'b0, AW'(3), '0);
      drain();

      // Reset during the WRITE cycle must abort the store and drop the response
      send(1'b1, AW'(7), '0);
      drain();
      n = 0;
      while (!bus_if.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = AW'(7);
      bus_if.req_wdata = 32'hA5A5_A5A5;
      @(posedge clk);
      #2;
      chk("mid_write_cs", 64'(bus_if.ram_chip_select), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_cs", 64'(bus_if.ram_chip_select), 64'(0));
      chk("abort_we", 64'(bus_if.ram_write_enable), 64'(0));
      chk("abort_rsp_valid", 64'(bus_if.rsp_valid), 64'(0));
      chk("abort_req_ready", 64'(bus_if.req_ready), 64'(0));
      bus_if.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_rsp", 64'(bus_if.rsp_valid), 64'(0));
      end
      send(1'b0, AW'(7), '0);
      drain();

      repeat (80) send(1'($urandom), AW'($urandom_range(0, 15)), $urandom);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
